// File: rtl/exe_stage_muldiv_if.sv
// ----------------------------------------------------------------------------
// exe_stage_muldiv_if
//   Bundles the ID/EXE pipeline register outputs feeding the execute stage and
//   the execute-stage results feeding the EXE/MEM register.
//   master : the pipeline side (drives operands/controls, observes results)
//   slave  : the execute stage (consumes operands/controls, drives results)
//   Signals:
//     flush, pc, exe_cmd, alu_inp1, alu_inp2, reg2, branch_type,
//     wb_en, mem_read, mem_write, dest          -> into the execute stage
//     alu_result, st_val, dest_out, wb_en_out, mem_read_out, mem_write_out,
//     br_taken, br_addr, freez_out              -> out of the execute stage
// ----------------------------------------------------------------------------
interface exe_stage_muldiv_if #(
  parameter int len = 32
);
  logic           flush;
  logic [len-1:0] pc;
  logic [3:0]     exe_cmd;
  logic [31:0]    alu_inp1;
  logic [31:0]    alu_inp2;
  logic [31:0]    reg2;
  logic [1:0]     branch_type;
  logic           wb_en;
  logic           mem_read;
  logic           mem_write;
  logic [4:0]     dest;

  logic [31:0]    alu_result;
  logic [31:0]    st_val;
  logic [4:0]     dest_out;
  logic           wb_en_out;
  logic           mem_read_out;
  logic           mem_write_out;
  logic           br_taken;
  logic [len-1:0] br_addr;
  logic           freez_out;

  modport master (
    output flush, pc, exe_cmd, alu_inp1, alu_inp2, reg2, branch_type,
           wb_en, mem_read, mem_write, dest,
    input  alu_result, st_val, dest_out, wb_en_out, mem_read_out,
           mem_write_out, br_taken, br_addr, freez_out
  );

  modport slave (
    input  flush, pc, exe_cmd, alu_inp1, alu_inp2, reg2, branch_type,
           wb_en, mem_read, mem_write, dest,
    output alu_result, st_val, dest_out, wb_en_out, mem_read_out,
           mem_write_out, br_taken, br_addr, freez_out
  );
endinterface

// File: rtl/exe_stage_muldiv.sv
// ----------------------------------------------------------------------------
// exe_stage_muldiv
//   Execute stage of the pipeline. All ALU ops and branch resolution complete
//   in a single cycle. MUL (low 32 bits, unsigned) and DIV (unsigned quotient)
//   run on a shared iterative engine taking 32 steps; while it works the stage
//   raises freez_out to hold IF/ID and ID/EXE, and suppresses the write-back
//   and memory control bits so nothing bogus reaches EXE/MEM.
//   Ports:
//     clock : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : exe_stage_muldiv_if.slave (operands/controls in, results out)
// ----------------------------------------------------------------------------
module exe_stage_muldiv #(
  parameter int len = 32
) (
  input  logic               clock,
  input  logic               reset,
  exe_stage_muldiv_if.slave  bus
);

  localparam logic [3:0] CMD_ADD = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0100;
  localparam logic [3:0] CMD_OR  = 4'b0101;
  localparam logic [3:0] CMD_NOR = 4'b0110;
  localparam logic [3:0] CMD_XOR = 4'b0111;
  localparam logic [3:0] CMD_SLL = 4'b1000;
  localparam logic [3:0] CMD_SRA = 4'b1001;
  localparam logic [3:0] CMD_SRL = 4'b1010;
  localparam logic [3:0] CMD_MUL = 4'b1100;
  localparam logic [3:0] CMD_DIV = 4'b1101;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q;
  logic [4:0]  cnt_q;
  logic        isDiv_q;
  // opA_q: multiplicand (shifted left) for MUL, dividend/quotient for DIV.
  // opB_q: multiplier (shifted right) for MUL, divisor for DIV.
  // accum_q: product accumulator for MUL, partial remainder for DIV.
  logic [31:0] opA_q;
  logic [31:0] opB_q;
  logic [31:0] accum_q;

  logic        isMulDiv;
  logic        startOp;
  logic        useEngine;
  logic [4:0]  shamt;
  logic [31:0] aluComb;
  logic [31:0] engineResult;

  logic [31:0] mulAcc_d;
  logic [32:0] divShift;
  logic [32:0] divTrial;
  logic        divFits;
  logic [31:0] divRem_d;
  logic [31:0] divQuot_d;

  assign isMulDiv  = (bus.exe_cmd == CMD_MUL) || (bus.exe_cmd == CMD_DIV);
  assign startOp   = isMulDiv && !bus.flush;
  assign useEngine = (state_q == DONE) && !bus.flush;
  assign shamt     = bus.alu_inp2[4:0];

  // Single-cycle ALU. MUL/DIV codes land in the default arm: outside DONE
  // their value is never consumed because the stage is stalled or flushed.
  always_comb begin
    aluComb = 32'h0;
    unique case (bus.exe_cmd)
      CMD_ADD: aluComb = bus.alu_inp1 + bus.alu_inp2;
      CMD_SUB: aluComb = bus.alu_inp1 - bus.alu_inp2;
      CMD_AND: aluComb = bus.alu_inp1 & bus.alu_inp2;
      CMD_OR:  aluComb = bus.alu_inp1 | bus.alu_inp2;
      CMD_NOR: aluComb = ~(bus.alu_inp1 | bus.alu_inp2);
      CMD_XOR: aluComb = bus.alu_inp1 ^ bus.alu_inp2;
      CMD_SLL: aluComb = bus.alu_inp1 << shamt;
      CMD_SRA: aluComb = $unsigned($signed(bus.alu_inp1) >>> shamt);
      CMD_SRL: aluComb = bus.alu_inp1 >> shamt;
      default: aluComb = 32'h0;
    endcase
  end

  // One step of each algorithm. Division is restoring: bring down the next
  // dividend bit, subtract the divisor if it fits, record the quotient bit.
  // The 33-bit trial keeps the borrow so a zero divisor always "fits",
  // which is what produces the all-ones quotient for divide by zero.
  always_comb begin
    mulAcc_d  = accum_q + (opB_q[0] ? opA_q : 32'h0);
    divShift  = {accum_q, opA_q[31]};
    divTrial  = divShift - {1'b0, opB_q};
    divFits   = !divTrial[32];
    divRem_d  = divFits ? divTrial[31:0] : divShift[31:0];
    divQuot_d = {opA_q[30:0], divFits};
  end

  assign engineResult = isDiv_q ? opA_q : accum_q;

  // MUL/DIV sequencer. IDLE latches operands when a MUL/DIV arrives, BUSY
  // performs exactly 32 steps, DONE presents the result for one cycle while
  // the upstream registers advance. A flush abandons the operation.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      isDiv_q <= 1'b0;
      opA_q   <= 32'h0;
      opB_q   <= 32'h0;
      accum_q <= 32'h0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (startOp) begin
            isDiv_q <= (bus.exe_cmd == CMD_DIV);
            opA_q   <= bus.alu_inp1;
            opB_q   <= bus.alu_inp2;
            accum_q <= 32'h0;
            cnt_q   <= 5'd0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            if (isDiv_q) begin
              accum_q <= divRem_d;
              opA_q   <= divQuot_d;
            end else begin
              accum_q <= mulAcc_d;
              opA_q   <= opA_q << 1;
              opB_q   <= opB_q >> 1;
            end
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The stall is gated by reset so that asserting reset mid-operation drops
  // freez_out at once even though the MUL/DIV command is still presented.
  always_comb begin
    bus.freez_out = reset &&
                    (((state_q == IDLE) && startOp) ||
                     ((state_q == BUSY) && !bus.flush));
  end

  // Result and pass-through fields toward EXE/MEM; control bits are killed
  // while stalled so the bubble does not write back or touch memory.
  always_comb begin
    bus.alu_result    = useEngine ? engineResult : aluComb;
    bus.st_val        = bus.reg2;
    bus.dest_out      = bus.dest;
    bus.wb_en_out     = bus.wb_en     && !bus.freez_out;
    bus.mem_read_out  = bus.mem_read  && !bus.freez_out;
    bus.mem_write_out = bus.mem_write && !bus.freez_out;
  end

  // Branch resolution is independent of the ALU op.
  always_comb begin
    bus.br_addr  = bus.pc + len'(bus.alu_inp2 << 2);
    bus.br_taken = 1'b0;
    unique case (bus.branch_type)
      2'b00: bus.br_taken = 1'b0;
      2'b01: bus.br_taken = (bus.alu_inp1 == 32'h0);
      2'b10: bus.br_taken = (bus.alu_inp1 != bus.reg2);
      2'b11: bus.br_taken = 1'b1;
      default: bus.br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exe_stage_muldiv.sv
// ----------------------------------------------------------------------------
// tb_exe_stage_muldiv
//   Directed plus randomized bench for the execute stage. Expected values come
//   from a plain-arithmetic reference of the instruction set and of the
//   documented stall timing.
// ----------------------------------------------------------------------------
module tb_exe_stage_muldiv;

  logic clock;
  logic reset;
  int   compared;
  int   mismatched;

  exe_stage_muldiv_if #(.len(32)) bus ();

  exe_stage_muldiv #(.len(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per period
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard time limit so the run can never hang
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference result of an operation, from the instruction definitions
  function automatic logic [31:0] refAlu(input logic [3:0] cmd,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh;
    logic [63:0] prod;
    sh = b % 32;
    case (cmd)
      4'b0000: refAlu = a + b;
      4'b0010: refAlu = a - b;
      4'b0100: refAlu = a & b;
      4'b0101: refAlu = a | b;
      4'b0110: refAlu = ~(a | b);
      4'b0111: refAlu = a ^ b;
      4'b1000: refAlu = a << sh;
      4'b1001: refAlu = $unsigned($signed(a) >>> sh);
      4'b1010: refAlu = a >> sh;
      4'b1100: begin
        prod   = 64'(a) * 64'(b);
        refAlu = prod[31:0];
      end
      4'b1101: refAlu = (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      default: refAlu = 32'h0;
    endcase
  endfunction

  function automatic logic refTaken(input logic [1:0] bt,
                                    input logic [31:0] a,
                                    input logic [31:0] r2);
    case (bt)
      2'b01:   refTaken = (a == 32'h0);
      2'b10:   refTaken = (a != r2);
      2'b11:   refTaken = 1'b1;
      default: refTaken = 1'b0;
    endcase
  endfunction

  task automatic applyStimulus(input logic [3:0]  cmd,
                               input logic [31:0] a,
                               input logic [31:0] b,
                               input logic [31:0] r2,
                               input logic [1:0]  bt,
                               input logic [31:0] pcv,
                               input logic [2:0]  ctl,
                               input logic [4:0]  dst);
    bus.exe_cmd     = cmd;
    bus.alu_inp1    = a;
    bus.alu_inp2    = b;
    bus.reg2        = r2;
    bus.branch_type = bt;
    bus.pc          = pcv;
    bus.wb_en       = ctl[2];
    bus.mem_read    = ctl[1];
    bus.mem_write   = ctl[0];
    bus.dest        = dst;
  endtask

  task automatic checkOutput(input string tag,
                             input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=0x%08h required=0x%08h",
             tag, observed, expected);
    end
  endtask

  // Issue one MUL/DIV at a negedge and follow it through its 33 stalled
  // cycles to the result cycle, then replace it with a harmless ADD.
  task automatic runMulDiv(input string tag, input logic [3:0] cmd,
                           input logic [31:0] a, input logic [31:0] b);
    logic [31:0] expected;
    expected = refAlu(cmd, a, b);
    applyStimulus(cmd, a, b, 32'h0, 2'b00, 32'h0, 3'b100, 5'd9);
    for (int i = 0; i < 33; i++) begin
      #1;
      checkOutput({tag, " stall freez"}, {31'b0, bus.freez_out}, 32'd1);
      checkOutput({tag, " stall wb_en"}, {31'b0, bus.wb_en_out}, 32'd0);
      @(negedge clock);
    end
    #1;
    checkOutput({tag, " done freez"},  {31'b0, bus.freez_out}, 32'd0);
    checkOutput({tag, " done result"}, bus.alu_result, expected);
    checkOutput({tag, " done wb_en"},  {31'b0, bus.wb_en_out}, 32'd1);
    @(negedge clock);
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 3'b000, 5'd0);
    #1;
    checkOutput({tag, " after freez"}, {31'b0, bus.freez_out}, 32'd0);
  endtask

  // Single-cycle op: every output must be right in the same cycle
  task automatic checkSingle(input string tag);
    #1;
    checkOutput({tag, " result"}, bus.alu_result,
                refAlu(bus.exe_cmd, bus.alu_inp1, bus.alu_inp2));
    checkOutput({tag, " freez"}, {31'b0, bus.freez_out}, 32'd0);
    checkOutput({tag, " taken"}, {31'b0, bus.br_taken},
                {31'b0, refTaken(bus.branch_type, bus.alu_inp1, bus.reg2)});
    checkOutput({tag, " braddr"}, bus.br_addr, bus.pc + bus.alu_inp2 * 4);
    checkOutput({tag, " stval"}, bus.st_val, bus.reg2);
    checkOutput({tag, " ctl"},
                {27'b0, bus.dest_out, bus.wb_en_out, bus.mem_read_out, bus.mem_write_out} >> 0,
                {27'b0, bus.dest, bus.wb_en, bus.mem_read, bus.mem_write});
  endtask

  logic [3:0]  aluCodes [0:12];
  logic [31:0] ra;
  logic [31:0] rb;

  initial begin
    compared   = 0;
    mismatched = 0;
    aluCodes   = '{4'b0000, 4'b0010, 4'b0100, 4'b0101, 4'b0110, 4'b0111,
                   4'b1000, 4'b1001, 4'b1010, 4'b0001, 4'b0011, 4'b1011,
                   4'b1111};

    // Reset with a MUL presented: no stall may be requested
    reset     = 1'b0;
    bus.flush = 1'b0;
    applyStimulus(4'b1100, 32'h3, 32'h5, 32'h0, 2'b00, 32'h0, 3'b100, 5'd1);
    #1;
    checkOutput("reset freez", {31'b0, bus.freez_out}, 32'd0);
    checkOutput("reset wb_en", {31'b0, bus.wb_en_out}, 32'd1);
    @(negedge clock);
    applyStimulus(4'b0000, 32'h0, 32'h0, 32'h0, 2'b00, 32'h0, 3'b000, 5'd0);
    @(negedge clock);
    reset = 1'b1;

    // ADD overflow wrap and SRA sign fill, same cycle
    applyStimulus(4'b0000, 32'h7FFF_FFFF, 32'h1, 32'h0, 2'b00, 32'h0, 3'b100, 5'd3);
    #1;
    checkOutput("add wrap", bus.alu_result, 32'h8000_0000);
    checkSingle("add");
    @(negedge clock);
    applyStimulus(4'b1001, 32'h8000_0000, 32'h4, 32'h0, 2'b00, 32'h0, 3'b100, 5'd3);
    #1;
    checkOutput("sra sign", bus.alu_result, 32'hF800_0000);
    @(negedge clock);

    // Branch decode
    applyStimulus(4'b0000, 32'h3, 32'h0, 32'h3, 2'b10, 32'h0, 3'b000, 5'd0);
    #1;
    checkOutput("bne equal", {31'b0, bus.br_taken}, 32'd0);
    @(negedge clock);
    applyStimulus(4'b0000, 32'h0, 32'h4, 32'h0, 2'b01, 32'h100, 3'b000, 5'd0);
    #1;
    checkOutput("bez taken", {31'b0, bus.br_taken}, 32'd1);
    checkOutput("bez addr",  bus.br_addr, 32'h110);
    @(negedge clock);

    // Directed MUL/DIV cases, including divide by zero
    runMulDiv("mul basic", 4'b1100, 32'h0001_0003, 32'h0000_0005);
    checkOutput("mul basic value", refAlu(4'b1100, 32'h0001_0003, 32'h5), 32'h0005_000F);
    @(negedge clock);
    runMulDiv("div 100/7", 4'b1101, 32'd100, 32'd7);
    @(negedge clock);
    runMulDiv("div by 0", 4'b1101, 32'd5, 32'd0);
    @(negedge clock);
    runMulDiv("mul wrap", 4'b1100, 32'hFFFF_FFFF, 32'h2);
    @(negedge clock);

    // Randomized single-cycle ops with random branches and controls
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = (i % 4 == 0) ? 32'h0 : $urandom;
      applyStimulus(aluCodes[$urandom_range(0, 12)], (i % 5 == 0) ? 32'h0 : ra, rb,
                    (i % 3 == 0) ? ra : $urandom, 2'($urandom_range(0, 3)),
                    $urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
      checkSingle("rand alu");
      @(negedge clock);
    end

    // Randomized MUL/DIV
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000));
      runMulDiv("rand muldiv", (i % 2 == 0) ? 4'b1100 : 4'b1101, ra, rb);
      @(negedge clock);
    end

    // Flush during BUSY at cnt=10, then an ADD must not stall
    applyStimulus(4'b1100, 32'h1234, 32'h5678, 32'h0, 2'b00, 32'h0, 3'b100, 5'd2);
    #1;
    checkOutput("flush start freez", {31'b0, bus.freez_out}, 32'd1);
    @(negedge clock);
    repeat (10) @(negedge clock);
    bus.flush = 1'b1;
    #1;
    checkOutput("flush cycle freez", {31'b0, bus.freez_out}, 32'd0);
    @(negedge clock);
    bus.flush = 1'b0;
    applyStimulus(4'b0000, 32'd20, 32'd22, 32'h0, 2'b00, 32'h0, 3'b100, 5'd2);
    #1;
    checkOutput("post flush add", bus.alu_result, 32'd42);
    checkOutput("post flush freez", {31'b0, bus.freez_out}, 32'd0);
    @(negedge clock);
    #1;
    checkOutput("post flush idle", {31'b0, bus.freez_out}, 32'd0);
    @(negedge clock);

    // Reset during BUSY at cnt=20, then a full MUL again
    applyStimulus(4'b1100, 32'h7, 32'h6, 32'h0, 2'b00, 32'h0, 3'b100, 5'd4);
    @(negedge clock);
    repeat (20) @(negedge clock);
    #1;
    checkOutput("pre reset freez", {31'b0, bus.freez_out}, 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("mid reset freez", {31'b0, bus.freez_out}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    runMulDiv("mul after reset", 4'b1100, 32'h7, 32'h6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
